// File: rtl/pid_core_mc.sv
// Multi-channel PID core: per-channel coefficients loaded from EEPROM, one shared multiplier, round-robin service.
// Build option PID_ANTIWINDUP_EN: integrator update is committed only when the output does not clip further.
module pid_core_mc #(
    parameter int NCH  = 2,
    parameter int DW   = 14,
    parameter int CW   = 8,
    parameter int FRAC = 4,
    parameter int IW   = 18,
    parameter int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    meas_vld,
    input  logic [NCH*DW-1:0] meas,
    input  logic              cfg_wr,
    input  logic              cfg_clr,
    input  logic [CHW-1:0]    cfg_ch,
    input  logic [DW-1:0]     cfg_data,
    output logic              eep_req,
    output logic [CHW+1:0]    eep_addr,
    input  logic              eep_ack,
    input  logic [CW-1:0]     eep_rd_data,
    output logic [DW-1:0]     duty,
    output logic [CHW-1:0]    duty_ch,
    output logic              duty_vld,
    output logic              busy
);
    localparam int AW = CW + IW + 3;
    localparam int PW = CW + IW + 1;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_ERR, S_MP, S_MI, S_MD, S_OUT} state_t;
    state_t state_reg, state_next;

    logic signed [DW-1:0] setpt_reg    [NCH];
    logic signed [DW-1:0] prev_err_reg [NCH];
    logic signed [DW-1:0] sample_reg   [NCH];
    logic signed [IW-1:0] integ_reg    [NCH];
    logic signed [DW-1:0] meas_slice   [NCH];
    logic [CW-1:0]        coef_reg     [NCH][3];

    logic [NCH-1:0]       pend_reg, grant_clr;
    logic [CHW-1:0]       rr_reg, grant_reg, grant_next;
    logic                 grant_found;
    logic [CHW-1:0]       rd_ch_reg;
    logic [1:0]           rd_k_reg;
    logic                 eep_req_reg, init_last;
    logic signed [DW-1:0] err_reg, diff_reg, duty_reg;
    logic signed [IW-1:0] sum_stage_reg;
    logic signed [AW-1:0] acc_reg, acc_sum, acc_sh;
    logic [CHW-1:0]       duty_ch_reg;
    logic                 duty_vld_reg;

    logic signed [DW:0]   err_full, diff_full;
    logic signed [IW:0]   sum_full;
    logic signed [DW-1:0] err_sat, diff_sat, duty_sat;
    logic signed [IW-1:0] sum_sat;
    logic [CW-1:0]        mul_k;
    logic signed [IW-1:0] mul_op;
    logic signed [PW-1:0] prod;
    logic                 clip_hi, clip_lo;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_slice
            assign meas_slice[gi] = meas[gi*DW +: DW];
        end
    endgenerate

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [DW:0] v);
        if (v[DW] != v[DW-1])
            return v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        return v[DW-1:0];
    endfunction

    function automatic logic signed [IW-1:0] sat_iw(input logic signed [IW:0] v);
        if (v[IW] != v[IW-1])
            return v[IW] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
        return v[IW-1:0];
    endfunction

    // First pending channel at or after rr; descending scan lets the smallest offset win.
    always_comb begin
        grant_found = 1'b0;
        grant_next  = rr_reg;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (pend_reg[(int'(rr_reg) + k) % NCH]) begin
                grant_found = 1'b1;
                grant_next  = CHW'((int'(rr_reg) + k) % NCH);
            end
        end
    end

    assign grant_clr = (state_reg == S_IDLE && grant_found) ? (NCH'(1) << grant_next) : '0;

    always_comb begin
        err_full  = (DW+1)'(setpt_reg[grant_reg]) - (DW+1)'(sample_reg[grant_reg]);
        err_sat   = sat_dw(err_full);
        sum_full  = (IW+1)'(integ_reg[grant_reg]) + (IW+1)'(err_sat);
        sum_sat   = sat_iw(sum_full);
        diff_full = (DW+1)'(err_sat) - (DW+1)'(prev_err_reg[grant_reg]);
        diff_sat  = sat_dw(diff_full);
    end

    // Shared multiplier: coefficient is zero-extended, operand is signed.
    always_comb begin
        mul_k  = '0;
        mul_op = '0;
        case (state_reg)
            S_MP: begin mul_k = coef_reg[grant_reg][0]; mul_op = IW'(err_reg);  end
            S_MI: begin mul_k = coef_reg[grant_reg][1]; mul_op = sum_stage_reg; end
            S_MD: begin mul_k = coef_reg[grant_reg][2]; mul_op = IW'(diff_reg); end
            default: ;
        endcase
    end

    assign prod    = $signed({1'b0, mul_k}) * mul_op;
    assign acc_sum = acc_reg + AW'(prod);
    assign acc_sh  = acc_reg >>> FRAC;
    assign clip_hi = !acc_sh[AW-1] && (|acc_sh[AW-2:DW-1]);
    assign clip_lo = acc_sh[AW-1] && !(&acc_sh[AW-2:DW-1]);
    assign duty_sat = clip_hi ? {1'b0, {(DW-1){1'b1}}} :
                      clip_lo ? {1'b1, {(DW-1){1'b0}}} : acc_sh[DW-1:0];

`ifdef PID_ANTIWINDUP_EN
    logic commit;
    assign commit = !(clip_hi || clip_lo) || (clip_hi && err_reg[DW-1]) ||
                    (clip_lo && !err_reg[DW-1] && err_reg != '0);
`endif

    assign init_last = (rd_ch_reg == CHW'(NCH - 1)) && (rd_k_reg == 2'd2);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_INIT:  if (eep_req_reg && eep_ack && init_last) state_next = S_IDLE;
            S_IDLE:  if (grant_found) state_next = S_ERR;
            S_ERR:   state_next = S_MP;
            S_MP:    state_next = S_MI;
            S_MI:    state_next = S_MD;
            S_MD:    state_next = S_OUT;
            S_OUT:   state_next = S_IDLE;
            default: state_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_INIT;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg      <= '0;
            rr_reg        <= '0;
            grant_reg     <= '0;
            rd_ch_reg     <= '0;
            rd_k_reg      <= '0;
            eep_req_reg   <= 1'b0;
            err_reg       <= '0;
            diff_reg      <= '0;
            sum_stage_reg <= '0;
            acc_reg       <= '0;
            duty_reg      <= '0;
            duty_ch_reg   <= '0;
            duty_vld_reg  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                setpt_reg[i]    <= '0;
                prev_err_reg[i] <= '0;
                sample_reg[i]   <= '0;
                integ_reg[i]    <= '0;
                for (int k = 0; k < 3; k++) coef_reg[i][k] <= '0;
            end
        end else begin
            duty_vld_reg <= 1'b0;
            for (int i = 0; i < NCH; i++)
                if (meas_vld[i]) sample_reg[i] <= meas_slice[i];
            // A strobe on the grant edge keeps the channel pending.
            pend_reg <= (pend_reg & ~grant_clr) | meas_vld;

            case (state_reg)
                S_INIT: begin
                    if (!eep_req_reg) begin
                        eep_req_reg <= 1'b1;
                    end else if (eep_ack) begin
                        coef_reg[rd_ch_reg][rd_k_reg] <= eep_rd_data;
                        eep_req_reg <= 1'b0;
                        if (rd_k_reg == 2'd2) begin
                            rd_k_reg  <= '0;
                            rd_ch_reg <= init_last ? '0 : rd_ch_reg + CHW'(1);
                        end else begin
                            rd_k_reg <= rd_k_reg + 2'd1;
                        end
                    end
                end
                S_IDLE: begin
                    if (grant_found) begin
                        grant_reg <= grant_next;
                        rr_reg    <= (grant_next == CHW'(NCH - 1)) ? '0 : grant_next + CHW'(1);
                    end
                end
                S_ERR: begin
                    err_reg                 <= err_sat;
                    diff_reg                <= diff_sat;
                    sum_stage_reg           <= sum_sat;
                    prev_err_reg[grant_reg] <= err_sat;
                    acc_reg                 <= '0;
`ifndef PID_ANTIWINDUP_EN
                    integ_reg[grant_reg]    <= sum_sat;
`endif
                end
                S_MP, S_MI, S_MD: acc_reg <= acc_sum;
                S_OUT: begin
                    duty_reg     <= duty_sat;
                    duty_ch_reg  <= grant_reg;
                    duty_vld_reg <= 1'b1;
`ifdef PID_ANTIWINDUP_EN
                    if (commit) integ_reg[grant_reg] <= sum_stage_reg;
`endif
                end
                default: ;
            endcase

            // Placed last so a clear overrides any integrator/prev_err update on the same edge.
            if (cfg_wr && state_reg != S_INIT) begin
                setpt_reg[cfg_ch] <= cfg_data;
                if (cfg_clr) begin
                    integ_reg[cfg_ch]    <= '0;
                    prev_err_reg[cfg_ch] <= '0;
                end
            end
        end
    end

    assign eep_req  = eep_req_reg;
    assign eep_addr = {rd_ch_reg, rd_k_reg};
    assign duty     = duty_reg;
    assign duty_ch  = duty_ch_reg;
    assign duty_vld = duty_vld_reg;
    assign busy     = (state_reg != S_IDLE);
endmodule

// File: tb/tb_pid_core_mc.sv
// Scoreboard bench for pid_core_mc: randomized samples checked against an arithmetic PID model.
module tb_pid_core_mc;
    localparam int NCH = 2, DW = 14, CW = 8, FRAC = 4, IW = 18, CHW = 1;

    logic                 clk = 0, rst = 1;
    logic [NCH-1:0]       meas_vld = '0;
    logic [NCH*DW-1:0]    meas = '0;
    logic                 cfg_wr = 0, cfg_clr = 0;
    logic [CHW-1:0]       cfg_ch = '0;
    logic [DW-1:0]        cfg_data = '0;
    logic                 eep_req, eep_ack = 0;
    logic [CHW+1:0]       eep_addr;
    logic [CW-1:0]        eep_rd_data = '0;
    logic signed [DW-1:0] duty;
    logic [CHW-1:0]       duty_ch;
    logic                 duty_vld, busy;

    pid_core_mc #(.NCH(NCH), .DW(DW), .CW(CW), .FRAC(FRAC), .IW(IW)) dut (
        .clk(clk), .rst(rst), .meas_vld(meas_vld), .meas(meas),
        .cfg_wr(cfg_wr), .cfg_clr(cfg_clr), .cfg_ch(cfg_ch), .cfg_data(cfg_data),
        .eep_req(eep_req), .eep_addr(eep_addr), .eep_ack(eep_ack), .eep_rd_data(eep_rd_data),
        .duty(duty), .duty_ch(duty_ch), .duty_vld(duty_vld), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; int duty; int cyc; } exp_t;
    exp_t expq[$];
    exp_t mon_e;

    int checks = 0, errors = 0;
    int cyc = 0, vld_seen = 0;
    int cm [NCH][3];
    int m_setpt [NCH], m_sum [NCH], m_prev [NCH];
    int m_rr = 0;
    int ack_cnt = 0, stall_cfg = -1, resp_st = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input longint v, input int n);
        longint mx;
        mx = (longint'(1) << (n - 1)) - 1;
        if (v > mx) return int'(mx);
        if (v < -mx - 1) return int'(-mx - 1);
        return int'(v);
    endfunction

    // PID step in plain integer arithmetic; updates the channel's model state.
    function automatic int model_serve(input int ch, input int mv);
        int e, s, d, y;
        longint acc, raw;
        bit commit;
        e   = sat(longint'(m_setpt[ch]) - mv, DW);
        s   = sat(longint'(m_sum[ch]) + e, IW);
        d   = sat(longint'(e) - m_prev[ch], DW);
        acc = longint'(cm[ch][0]) * e + longint'(cm[ch][1]) * s + longint'(cm[ch][2]) * d;
        raw = acc >>> FRAC;
        y   = sat(raw, DW);
`ifdef PID_ANTIWINDUP_EN
        commit = (raw == longint'(y)) || (raw > longint'(y) && e < 0) || (raw < longint'(y) && e > 0);
`else
        commit = 1'b1;
`endif
        if (commit) m_sum[ch] = s;
        m_prev[ch] = e;
        return y;
    endfunction

    // EEPROM responder: acks each request after a stall, checks address order and the req gap.
    initial begin
        forever begin
            @(negedge clk);
            eep_ack = 0;
            if (!rst && eep_req) begin
                resp_st = (stall_cfg >= 0) ? stall_cfg : int'($urandom_range(0, 3));
                repeat (resp_st) @(negedge clk);
                if (!rst && eep_req) begin
                    chk("eep_addr", int'(eep_addr), ((ack_cnt / 3) << 2) | (ack_cnt % 3));
                    eep_ack = 1;
                    eep_rd_data = CW'(cm[int'(eep_addr[2])][int'(eep_addr[1:0]) % 3]);
                    ack_cnt++;
                    @(negedge clk);
                    eep_ack = 0;
                    if (!rst) chk("eep_req_gap", int'(eep_req), 0);
                end
            end
        end
    end

    // Monitor: every duty_vld pops one expectation.
    always @(negedge clk) begin
        if (!rst && duty_vld) begin
            vld_seen++;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_duty_vld: got ch=%0d duty=%0d, required no output", duty_ch, duty);
            end else begin
                mon_e = expq.pop_front();
                chk("duty_ch", int'(duty_ch), mon_e.ch);
                chk("duty", int'(duty), mon_e.duty);
                if (mon_e.cyc >= 0) chk("latency_cycle", cyc, mon_e.cyc);
                $display("txn ch=%0d duty=%0d cycle=%0d", duty_ch, duty, cyc);
            end
        end
    end

    task automatic send(input logic [NCH-1:0] mask, input int v0, input int v1, input bit lat);
        int vals [NCH];
        int base, n, c, start;
        vals[0] = v0;
        vals[1] = v1;
        meas_vld = mask;
        meas = {DW'(v1), DW'(v0)};
        base = cyc + 1;
        n = 0;
        start = m_rr;
        for (int k = 0; k < NCH; k++) begin
            c = (start + k) % NCH;
            if (mask[c]) begin
                n++;
                expq.push_back('{c, model_serve(c, vals[c]), lat ? base + 6 * n : -1});
                m_rr = (c + 1) % NCH;
            end
        end
        tick;
        meas_vld = '0;
    endtask

    task automatic cfg(input int ch, input int sp, input bit clr);
        cfg_wr = 1;
        cfg_clr = clr;
        cfg_ch = CHW'(ch);
        cfg_data = DW'(sp);
        tick;
        cfg_wr = 0;
        cfg_clr = 0;
        m_setpt[ch] = sp;
        if (clr) begin
            m_sum[ch] = 0;
            m_prev[ch] = 0;
        end
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((expq.size() != 0 || busy) && n < 300) begin
            tick;
            n++;
        end
        if (n >= 300) begin
            chk("drain_timeout", expq.size(), 0);
            expq.delete();
        end
    endtask

    task automatic set_coefs(input int kp0, input int ki0, input int kd0,
                             input int kp1, input int ki1, input int kd1);
        cm[0][0] = kp0; cm[0][1] = ki0; cm[0][2] = kd0;
        cm[1][0] = kp1; cm[1][1] = ki1; cm[1][2] = kd1;
    endtask

    task automatic do_reset(input int stall, input bit pend_init);
        int n;
        stall_cfg = stall;
        rst = 1;
        meas_vld = '0;
        cfg_wr = 0;
        repeat (2) @(posedge clk);
        ack_cnt = 0;
        expq.delete();
        m_rr = 0;
        for (int i = 0; i < NCH; i++) begin
            m_setpt[i] = 0;
            m_sum[i] = 0;
            m_prev[i] = 0;
        end
        @(negedge clk);
        chk("rst_duty", int'(duty), 0);
        chk("rst_duty_ch", int'(duty_ch), 0);
        chk("rst_duty_vld", int'(duty_vld), 0);
        chk("rst_eep_req", int'(eep_req), 0);
        chk("rst_eep_addr", int'(eep_addr), 0);
        chk("rst_busy", int'(busy), 1);
        @(posedge clk);
        #1 rst = 0;
        if (pend_init) begin
            tick;
            send(2'b11, int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192, 0);
        end
        n = 0;
        while (busy && n < 2000) begin
            tick;
            n++;
        end
        chk("init_done", int'(busy), 0);
        chk("init_reads", ack_cnt, 3 * NCH);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        // Proportional only.
        set_coefs(16, 0, 0, 16, 0, 0);
        do_reset(-1, 0);
        cfg(0, 100, 0);
        send(2'b01, 40, 0, 1);
        drain;

        // PI sequence on ch0.
        set_coefs(16, 16, 0, int'($urandom_range(0, 255)), 0, 0);
        do_reset(-1, 0);
        cfg(0, 100, 0);
        send(2'b01, 40, 0, 1);  drain;
        send(2'b01, 40, 0, 1);  drain;
        send(2'b01, 100, 0, 1); drain;

        // Error and duty saturation.
        set_coefs(255, 0, 0, 255, 0, 0);
        do_reset(-1, 0);
        cfg(0, 8191, 0);
        send(2'b01, -8192, 0, 1); drain;
        cfg(0, -8192, 0);
        send(2'b01, 8191, 0, 1);  drain;

        // Output pinned at full scale, then reversed: exposes integrator wind-up behaviour.
        set_coefs(0, 255, 0, 0, 255, 0);
        do_reset(-1, 0);
        cfg(0, 8191, 0);
        for (int i = 0; i < 10; i++) begin
            send(2'b01, -8192, 0, 1);
            drain;
        end
        cfg(0, -8192, 0);
        send(2'b01, 8191, 0, 1); drain;
        send(2'b01, 0, 0, 1);    drain;

        // Slow EEPROM, samples captured during INIT, simultaneous strobes.
        set_coefs(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        do_reset(5, 1);
        drain;
        send(2'b11, 300, -300, 1); drain;
        send(2'b11, -50, 77, 1);   drain;

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                cfg(int'($urandom_range(0, 1)), int'($urandom_range(0, 16383)) - 8192,
                    $urandom_range(0, 3) == 0);
            send(NCH'($urandom_range(1, 3)), int'($urandom_range(0, 16383)) - 8192,
                 int'($urandom_range(0, 16383)) - 8192, 1);
            drain;
        end

        // Reset while ch0 is in MI with ch1 pending: both samples are dropped.
        send(2'b10, 1234, 1234, 1); drain;
        meas_vld = 2'b11;
        meas = {DW'(500), DW'(-500)};
        tick;
        meas_vld = '0;
        repeat (3) tick;
        seen = vld_seen;
        do_reset(-1, 0);
        repeat (20) tick;
        chk("no_vld_after_abort", vld_seen - seen, 0);
        chk("duty_after_abort", int'(duty), 0);

        for (int i = 0; i < 6; i++) begin
            send(NCH'($urandom_range(1, 3)), int'($urandom_range(0, 16383)) - 8192,
                 int'($urandom_range(0, 16383)) - 8192, 1);
            drain;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
